// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared types and helpers for the fetch-stage program counter.
// Next-PC source select, instruction size, alignment check.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_RET,
    SEL_TRAP,
    SEL_HOLD
  } next_pc_sel_t;

  localparam int INSTR_BYTES = 4;

  function automatic logic is_aligned(
    input logic [1:0] lsb
  );
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/pc_unit_ras.sv
// ras_stack: circular return-address stack with push, pop and replace-top.
// A push when full overwrites the oldest entry; count saturates.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH+1);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_m1;

  assign ptr_m1 = ptr - PW'(1);
  assign top    = mem[ptr_m1];
  assign empty  = count == '0;
  assign full   = count == CW'(RAS_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full)
        count <= count + CW'(1);
    end else if (pop) begin
      ptr   <= ptr_m1;
      count <= count - CW'(1);
    end
  end

  // Entry contents need no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push)
      mem[ptr] <= wdata;
    else if (replace)
      mem[ptr_m1] <= wdata;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with branch, jump, trap and
// a hardware return-address stack for CALL/RET.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h100)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             BRANCH_TAKEN,
  input  logic [WIDTH-1:0] BRANCH_OFFSET,
  input  logic             JUMP,
  input  logic [WIDTH-1:0] JUMP_TARGET,
  input  logic             CALL,
  input  logic             RET,
  input  logic             TRAP,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_PLUS4,
  output logic             RAS_EMPTY,
  output logic             RAS_FULL,
  output logic             FAULT
);

  next_pc_sel_t     sel;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             misalign;
  logic             fault_next;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_replace;
  logic [$clog2(RAS_DEPTH+1)-1:0] ras_count;

  assign PC       = pc_q;
  assign PC_PLUS4 = pc_q + WIDTH'(INSTR_BYTES);

  always_comb begin
    sel = SEL_SEQ;
    priority case (1'b1)
      TRAP:         sel = SEL_TRAP;
      STALL:        sel = SEL_HOLD;
      RET:          sel = SEL_RET;
      JUMP:         sel = SEL_JUMP;
      BRANCH_TAKEN: sel = SEL_BRANCH;
      default:      sel = SEL_SEQ;
    endcase
  end

  always_comb begin
    target = PC_PLUS4;
    unique case (sel)
      SEL_BRANCH: target = pc_q + BRANCH_OFFSET;
      SEL_JUMP:   target = JUMP_TARGET;
      SEL_RET:    target = ras_top;
      SEL_TRAP:   target = TRAP_VECTOR;
      SEL_HOLD:   target = pc_q;
      default:    target = PC_PLUS4;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    if (sel == SEL_BRANCH || sel == SEL_JUMP || sel == SEL_RET)
      misalign = !is_aligned(target[1:0]);
  end

  // A faulting cycle redirects to the trap vector and cancels RAS updates.
  assign fault_next  = misalign || (sel == SEL_RET && RAS_EMPTY);
  assign pc_next     = fault_next ? TRAP_VECTOR : target;
  assign ras_push    = !fault_next && sel == SEL_JUMP && CALL;
  assign ras_replace = !fault_next && sel == SEL_RET && CALL && JUMP;
  assign ras_pop     = !fault_next && sel == SEL_RET && !(CALL && JUMP);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q  <= RESET_VECTOR;
      FAULT <= 1'b0;
    end else begin
      pc_q  <= pc_next;
      FAULT <= fault_next;
    end
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (CLK),
    .rst     (RESET),
    .push    (ras_push),
    .pop     (ras_pop),
    .replace (ras_replace),
    .wdata   (PC_PLUS4),
    .top     (ras_top),
    .count   (ras_count),
    .empty   (RAS_EMPTY),
    .full    (RAS_FULL)
  );

endmodule
